lamp_mode_arbiter: RTL
======================

Name: lamp_mode_arbiter

Overview:
- Output stage of the two-lane traffic light.
- Selects between the day-cycle controller lamps and the night-mode blinking-yellow lamps, driven by a debounced night request.
- Inserts an all-red clearance on every mode change and holds the inactive source (day_hold / night_reset).
- Blocks conflicting lamp patterns and latches a fault (all red) until reset.

Parameters:
- DEBOUNCE, 4, consecutive synchronized samples needed to change the filtered request (>=1).
- CLEAR_CYCLES, 3, all-red clearance length in clk cycles on each mode change (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- night_req  in  1  asynchronous night switch, 1 = night wanted.
- day_lamps  in  6  {Xa,Va,Da,Xb,Vb,Db} from the day controller.
- night_lamps  in  6  {Xa,Va,Da,Xb,Vb,Db} from the night blinker.
- lamps  out  6  {Xa,Va,Da,Xb,Vb,Db} registered lamp drive.
- day_hold  out  1  1 = day controller must freeze.
- night_reset  out  1  1 = night blinker held in reset.
- night_active  out  1  1 while in NIGHT.
- fault  out  1  sticky conflict flag.

Behaviour:
- Reset (async, active-high):
  - state=DAY, lamps=6'b100100 (Xa=Xb=1).
  - day_hold=0, night_reset=1, night_active=0, fault=0.
  - Filtered request req_f=0, debounce count 0, synchronizer flops 0.
- Request filtering:
  - night_req passes a 2-flop synchronizer.
  - req_f toggles on the DEBOUNCE-th consecutive edge where the synchronized value differs from req_f; any matching sample clears the count.
  - night_req step to req_f change = 2+DEBOUNCE edges.
- Conflict function on a 6-bit pattern: (Da&Db) | (Da&(Xa|Va)) | (Db&(Xb|Vb)).
  - Night conflict: any of Xa, Da, Xb, Db set in night_lamps.
- Register timing: all outputs are registered and updated on the same edge as the state; lamps lag the selected source by 1 cycle.
- States and transitions:
  - DAY:
    - lamps<=day_lamps; day_hold=0; night_reset=1.
    - req_f=1 -> DRAIN.
  - DRAIN:
    - As DAY (day controller keeps running).
    - req_f=0 -> DAY.
    - Else when day_lamps has Da=0 and Db=0 -> CLEAR_TO_NIGHT; on that edge lamps<=100100, day_hold<=1, counter<=CLEAR_CYCLES-1.
  - CLEAR_TO_NIGHT:
    - lamps=100100, day_hold=1, night_reset=1; counter decrements.
    - At 0: req_f=1 -> NIGHT (night_reset<=0, night_active<=1); req_f=0 -> DAY (day_hold<=0).
    - A req_f change mid-clearance does not shorten the clearance.
  - NIGHT:
    - lamps<=night_lamps; day_hold=1; night_reset=0.
    - req_f=0 -> CLEAR_TO_DAY; on that edge lamps<=100100, night_reset<=1, night_active<=0, counter reloaded.
  - CLEAR_TO_DAY:
    - lamps=100100, day_hold=1; counter decrements.
    - At 0: req_f=0 -> DAY (day_hold<=0); req_f=1 -> NIGHT.
  - FAULT:
    - Entered from DAY/DRAIN on a day conflict, or from NIGHT on a night conflict.
    - On the detecting edge lamps<=100100 instead of the conflicting pattern, so a conflict never reaches lamps.
    - fault=1, day_hold=1, night_reset=1, night_active=0; lamps stay 100100.
    - Exit only via reset.
- Priorities and boundaries:
  - Fault beats every transition.
  - Inputs are ignored during clearance states (no conflict check).
  - Counter width is clog2(CLEAR_CYCLES+1).
  - Reset mid-clearance or in FAULT returns to DAY immediately with reset values.

Test Plan:
- Reset then release; day_lamps=001100 (green A, red B) -> lamps=100100 during reset, 001100 one cycle after release; day_hold=0, night_reset=1.
- night_req 0->1 with DEBOUNCE=4 -> req_f after 6 edges; DRAIN holds while Da=1. Day drives 100100 -> next edge lamps=100100, day_hold=1; 3 all-red cycles; then night_reset=0, night_active=1, lamps follow 010010/000000.
- night_req glitch high for 3 cycles -> req_f stays 0; state DAY; lamps unchanged.
- In NIGHT, night_req ->0 -> after 6 edges: 3 cycles lamps=100100, night_reset=1; then DAY, day_hold=0, lamps=day_lamps.
- day_lamps=001001 in DAY -> lamps=100100 on the same edge (001001 never appears); fault=1 sticky; night_req activity ignored; reset clears.
- night_lamps=011010 in NIGHT -> FAULT, lamps=100100; reset asserted mid-CLEAR_TO_NIGHT -> DAY immediately, counter cleared.

Source files
------------

// File: rtl/lamp_mode_arbiter.sv
// Output stage of the two-lane traffic light: arbitrates day-controller and night-blinker lamps,
// inserts all-red clearance on mode changes and latches a fault on conflicting patterns.
module lamp_mode_arbiter #(
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned CLEAR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_night_req,
  input  logic [5:0] i_day_lamps,
  input  logic [5:0] i_night_lamps,
  output logic [5:0] o_lamps,
  output logic       o_day_hold,
  output logic       o_night_reset,
  output logic       o_night_active,
  output logic       o_fault
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam int unsigned CNT_W = $clog2(CLEAR_CYCLES + 1);

  localparam logic [5:0]       ALL_RED  = 6'b100100;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    StDay,
    StDrain,
    StClearToNight,
    StNight,
    StClearToDay,
    StFault
  } state_e;

  // Lamp bit order: {Xa, Va, Da, Xb, Vb, Db}
  function automatic logic f_conflict(input logic [5:0] p);
    return (p[3] & p[0]) | (p[3] & (p[5] | p[4])) | (p[0] & (p[2] | p[1]));
  endfunction

  logic [1:0]       r_sync;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_req_f;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;

  state_e           w_state_cand;
  state_e           w_state_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_day_conf;
  logic             w_night_conf;
  logic             w_day_side;
  logic [5:0]       w_lamps_d;
  logic             w_day_hold_d;
  logic             w_night_reset_d;
  logic             w_night_active_d;
  logic             w_fault_d;

  // Request synchronizer and debounce filter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync   <= 2'b00;
      r_db_cnt <= '0;
      r_req_f  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_night_req};
      if (r_sync[1] != r_req_f) begin
        if (r_db_cnt == DB_LAST) begin
          r_req_f  <= ~r_req_f;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_day_conf   = f_conflict(i_day_lamps);
  assign w_night_conf = i_night_lamps[5] | i_night_lamps[3] | i_night_lamps[2] | i_night_lamps[0];

  always_comb begin
    w_state_cand = r_state;
    w_cnt_d      = r_cnt;
    unique case (r_state)
      StDay: begin
        if (r_req_f) w_state_cand = StDrain;
      end
      StDrain: begin
        if (!r_req_f) begin
          w_state_cand = StDay;
        end else if (!i_day_lamps[3] && !i_day_lamps[0]) begin
          w_state_cand = StClearToNight;
          w_cnt_d      = CLR_LOAD;
        end
      end
      StClearToNight, StClearToDay: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end else begin
          w_state_cand = r_req_f ? StNight : StDay;
        end
      end
      StNight: begin
        if (!r_req_f) begin
          w_state_cand = StClearToDay;
          w_cnt_d      = CLR_LOAD;
        end
      end
      StFault: begin
        w_state_cand = StFault;
      end
      default: begin
        w_state_cand = StFault;
      end
    endcase

    // A conflicting source pattern is caught both while it is selected and on the edge it
    // would first be selected, so it can never reach the lamps.
    w_day_side = (r_state == StDay) || (r_state == StDrain) ||
                 (w_state_cand == StDay) || (w_state_cand == StDrain);
    w_state_d  = w_state_cand;
    if (w_day_conf && w_day_side) w_state_d = StFault;
    if (w_night_conf && ((r_state == StNight) || (w_state_cand == StNight))) w_state_d = StFault;

    w_lamps_d        = ALL_RED;
    w_day_hold_d     = 1'b1;
    w_night_reset_d  = 1'b1;
    w_night_active_d = 1'b0;
    w_fault_d        = 1'b0;
    case (w_state_d)
      StDay, StDrain: begin
        w_lamps_d    = i_day_lamps;
        w_day_hold_d = 1'b0;
      end
      StNight: begin
        w_lamps_d        = i_night_lamps;
        w_night_reset_d  = 1'b0;
        w_night_active_d = 1'b1;
      end
      StFault: begin
        w_fault_d = 1'b1;
      end
      default: begin
        w_lamps_d = ALL_RED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StDay;
      r_cnt          <= '0;
      o_lamps        <= ALL_RED;
      o_day_hold     <= 1'b0;
      o_night_reset  <= 1'b1;
      o_night_active <= 1'b0;
      o_fault        <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      o_lamps        <= w_lamps_d;
      o_day_hold     <= w_day_hold_d;
      o_night_reset  <= w_night_reset_d;
      o_night_active <= w_night_active_d;
      o_fault        <= w_fault_d;
    end
  end

endmodule
